regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file for the pipelined RISC-V core; successor to the fixed 32x32, two-read-port file.
- Adds configurable width, depth and read-port count.
- Adds hardwired-zero register, write-to-read bypass, and a post-reset sequential clear engine with a busy indication.
- Sits between decode (read) and writeback (write); the hazard unit consumes its bypassed data and optional pending bits.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS) derived locally
NRD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request (writeback stage)
wr_addr  input  AW  write register index
wr_data  input  XLEN  write data
rs_addr  input  NRD*AW  read indices; port k = bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
init_busy  output  1  high while the post-reset clear is running
wr_drop  output  1  combinational; high when wr_en is asserted but the write is discarded

Behaviour:
- The design uses one clock domain (clk). Reset rst is asynchronous and active-high. Asserting rst forces the FSM to CLEAR, clr_idx=0 and init_busy=1 immediately. The storage array is not reset directly.
- FSM CLEAR: each cycle writes 0 to entry clr_idx, then increments clr_idx.
  - When clr_idx==NREGS-1 is written, transition to READY at that edge.
  - CLEAR lasts exactly NREGS cycles after rst deasserts.
  - init_busy falls on the first READY cycle.
- FSM READY: stays until rst asserts. rst asserted mid-CLEAR or in READY restarts CLEAR from index 0.
- Writes in CLEAR:
  - wr_en is ignored.
  - wr_drop = wr_en.
  - Storage is not affected by the user write.
- Writes in READY: storage[wr_addr] <= wr_data on the rising edge when wr_en=1.
  - Exception: if ZERO_REG=1 and wr_addr==0, the write is discarded and wr_drop=1.
  - Otherwise wr_drop=0.
- Reads are combinational, zero latency, and the ports are independent. For each port k:
  - CLEAR: rd_data[k] = 0.
  - ZERO_REG=1 and rs_addr[k]==0: rd_data[k] = 0.
  - Bypass: if wr_en=1, the write is not dropped, and wr_addr==rs_addr[k], then rd_data[k] = wr_data (same-cycle forwarding).
  - Otherwise rd_data[k] = storage[rs_addr[k]].
- Multiple read ports addressing the same register all return the same value, including the bypassed value.
- Widths: all addresses are exactly AW bits, with no wrap handling needed. Data is not sign-extended or truncated.
- Reset values of outputs: rd_data=0 (all ports), init_busy=1, wr_drop=wr_en.

Optional Feature:
REGFILE_SCOREBOARD_EN: adds a per-register pending bitmap for hazard detection.
- Extra ports:
  - sb_set_en input 1
  - sb_set_addr input AW
  - rs_pending output NRD (bit k = pending[rs_addr[k]])
- Set and clear rules:
  - sb_set_en in READY sets pending[sb_set_addr].
  - A non-dropped write clears pending[wr_addr].
  - Same-cycle set and clear of the same index: set wins.
- rst asynchronously clears all bits. The bitmap is held at 0 during CLEAR.
- With ZERO_REG=1, register 0 is never pending.
- rs_pending[k] is forced 0 when the same-cycle bypass for port k is active.
- Without the macro: the ports, bitmap and logic are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset and clear (NREGS=32): pulse rst, release, hold wr_en=0.
   - Required: init_busy=1 for exactly 32 cycles, then 0.
   - Required: all reads return 0 before and after the clear.
2. Write then read: in READY, write 0xDEADBEEF to r5, wait one cycle.
   - Required: reading r5 on ports 0 and 1 returns 0xDEADBEEF; r6 reads 0.
3. Bypass: wr_en=1, wr_addr=7, wr_data=0x1234, rs_addr port0=7 in the same cycle.
   - Required: rd_data port0=0x1234 combinationally.
   - Required: the value persists the next cycle with wr_en=0.
4. Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0.
   - Required: wr_drop=1 and r0 reads 0, including in the bypass cycle.
   - With ZERO_REG=0: r0 reads 0xFFFFFFFF.
5. Reset mid-operation: assert rst at CLEAR cycle 10, release; assert wr_en to r3 during CLEAR.
   - Required: the clear restarts and init_busy lasts a full 32 cycles.
   - Required: wr_drop=1 and r3 reads 0 in READY.
6. Scoreboard (REGFILE_SCOREBOARD_EN, NRD=3): set r9 pending, read r9 on port 2.
   - Required: rs_pending[2]=1.
   - Same-cycle write to r9 plus set of r9: the bit stays 1.
   - A later write to r9 alone: the bit returns to 0 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with post-reset clear engine
// Optional feature macro: REGFILE_SCOREBOARD_EN (per-register pending bitmap, rs_pending outputs)
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NREGS)-1:0]      wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic [NRD*$clog2(NREGS)-1:0]  rs_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic                          init_busy,
    output logic                          wr_drop
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                          sb_set_en,
    input  logic [$clog2(NREGS)-1:0]      sb_set_addr,
    output logic [NRD-1:0]                rs_pending
`endif
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_idx;
    logic [XLEN-1:0]   mem [NREGS];
    logic              clearing;
    logic              zero_hit;
    logic              wr_ok;

    assign clearing  = (state == S_CLEAR);
    assign init_busy = clearing;

    // A user write lands only in READY and never on the hardwired zero register
    assign zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok    = wr_en && !clearing && !zero_hit;
    assign wr_drop  = wr_en && !wr_ok;

    // Clear engine: walk every index once after reset, then sit in READY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= S_READY;
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

    // Storage has no reset; the clear engine zeroes it one entry per cycle
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    // Set beats clear on the same index because it is applied last
    always_comb begin
        pending_nxt = pending;
        if (wr_ok) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (sb_set_en) begin
            pending_nxt[sb_set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    // Pending bitmap is held empty while the file is being cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (clearing) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          byp;

        assign ra  = rs_addr[k*AW +: AW];
        assign byp = wr_ok && (wr_addr == ra);

        assign rd_data[k*XLEN +: XLEN] =
            clearing                          ? '0 :
            ((ZERO_REG != 0) && (ra == '0))   ? '0 :
            byp                               ? wr_data :
                                                mem[ra];
`ifdef REGFILE_SCOREBOARD_EN
        assign rs_pending[k] = pending[ra] && !byp;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp against a behavioural model
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rd_z, rd_n;
    logic                 busy_z, busy_n;
    logic                 drop_z, drop_n;
`ifdef REGFILE_SCOREBOARD_EN
    logic                 sb_set_en;
    logic [AW-1:0]        sb_set_addr;
    logic [NRD-1:0]       pend_z, pend_n;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;

    // Behavioural model: index 0 = ZERO_REG=1 instance, 1 = ZERO_REG=0 instance
    int              clear_left;
    logic [XLEN-1:0] mem  [2][NREGS];
    bit              pend [2][NREGS];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rd_data(rd_z), .init_busy(busy_z), .wr_drop(drop_z)
`ifdef REGFILE_SCOREBOARD_EN
        , .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .rs_pending(pend_z)
`endif
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rd_data(rd_n), .init_busy(busy_n), .wr_drop(drop_n)
`ifdef REGFILE_SCOREBOARD_EN
        , .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .rs_pending(pend_n)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit exp_drop(input int d);
        return wr_en && ((clear_left > 0) || (d == 0 && wr_addr == 0));
    endfunction

    function automatic bit exp_fwd(input int d, input logic [AW-1:0] a);
        return wr_en && !exp_drop(d) && (wr_addr == a);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int d, input logic [AW-1:0] a);
        if (clear_left > 0)   return '0;
        if (d == 0 && a == 0) return '0;
        if (exp_fwd(d, a))    return wr_data;
        return mem[d][a];
    endfunction

    task automatic model_clear();
        clear_left = NREGS;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NREGS; i++) begin
                mem[d][i]  = '0;
                pend[d][i] = 1'b0;
            end
    endtask

    // Check every output at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        logic [NRD*XLEN-1:0] rd;
        logic [AW-1:0]       a;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rd = (d == 0) ? rd_z : rd_n;
            check($sformatf("init_busy_i%0d", d), (d == 0) ? busy_z : busy_n, clear_left > 0);
            check($sformatf("wr_drop_i%0d", d), (d == 0) ? drop_z : drop_n, exp_drop(d));
            for (int k = 0; k < NRD; k++) begin
                a = rs_addr[k*AW +: AW];
                check($sformatf("rd_i%0d_p%0d_r%0d", d, k, a), rd[k*XLEN +: XLEN], exp_rd(d, a));
`ifdef REGFILE_SCOREBOARD_EN
                check($sformatf("pend_i%0d_p%0d_r%0d", d, k, a),
                      (d == 0) ? pend_z[k] : pend_n[k], pend[d][a] && !exp_fwd(d, a));
`endif
            end
        end
        if (!rst && busy_z) busy_cnt++;
        @(posedge clk);
        if (rst) begin
            clear_left = NREGS;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wr_en && !exp_drop(d)) begin
                    mem[d][wr_addr]  = wr_data;
                    pend[d][wr_addr] = 1'b0;
                end
`ifdef REGFILE_SCOREBOARD_EN
                if (sb_set_en) pend[d][sb_set_addr] = 1'b1;
`endif
                if (d == 0) pend[d][0] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_clear();
        repeat (n) cycle();
        rst = 1'b0;
        busy_cnt = 0;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
        sb_set_en = 1'b0; sb_set_addr = '0;
`endif
        model_clear();
        #1;

        // Reset and full clear with random read addresses
        do_reset(3);
        for (int i = 0; i < 40; i++) begin
            set_rs(AW'($urandom), AW'($urandom));
            cycle();
        end
        check("busy_len_first", busy_cnt, 32);

        // Write then read back on both ports
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rs(5, 6);
        cycle();
        wr_en = 1'b0; set_rs(5, 5); cycle();
        set_rs(6, 5); cycle();

        // Same-cycle bypass, then persistence
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1234; set_rs(7, 7);
        cycle();
        wr_en = 1'b0; cycle();

        // Zero register behaviour on both instances, including the bypass cycle
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; set_rs(0, 0);
        cycle();
        wr_en = 1'b0; cycle();

        // Reset in the middle of a clear, with a write attempt during clear
        do_reset(2);
        repeat (10) cycle();
        do_reset(1);
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5A5A5A5; set_rs(3, 5);
        repeat (20) cycle();
        wr_en = 1'b0;
        repeat (20) cycle();
        check("busy_len_restart", busy_cnt, 32);
        set_rs(3, 3); cycle();

`ifdef REGFILE_SCOREBOARD_EN
        // Pending set, same-cycle set+write, then plain write clears
        sb_set_en = 1'b1; sb_set_addr = 9; set_rs(9, 9); cycle();
        sb_set_en = 1'b0; cycle();
        sb_set_en = 1'b1; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; cycle();
        sb_set_en = 1'b0; wr_en = 1'b0; cycle();
        wr_en = 1'b1; cycle();
        wr_en = 1'b0; cycle();
`endif

        // Randomized traffic with frequent address collisions
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(0, 7));
            wr_data = $urandom;
            set_rs(($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 7)));
`ifdef REGFILE_SCOREBOARD_EN
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = AW'($urandom_range(0, 7));
`endif
            if (i == 200) do_reset(1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
